// File: rtl/match_report_fifo.sv
// match_report_fifo
//   Collector at the output end of the NFA engine. Every character cycle that
//   has at least one rule match produces one {match vector, byte offset} record.
//   The record goes into a FIFO that the host drains with a valid/ready
//   handshake. Records that arrive while the FIFO is full are dropped and
//   counted.
//   All state changes on the falling edge of clk, the same edge the engine
//   counters use.
// Ports
//   clk        engine clock (active edge: negedge)
//   rst        asynchronous reset, active low
//   en         character-valid strobe shared with the engine
//   match      per-rule match lines for the current character
//   rd_ready   host accepts the head record
//   rd_valid   FIFO non-empty, head record presented
//   rd_match   match vector of the head record
//   rd_offset  byte offset of the head record
//   level      number of stored records, 0..DEPTH
//   overflow   sticky drop flag
//   drop_cnt   saturating count of dropped records
//   clr_ovf    synchronous clear of overflow and drop_cnt
module match_report_fifo #(
  parameter int NUM_MATCH = 8,
  parameter int OFF_W     = 16,
  parameter int DEPTH     = 16,
  parameter int AW        = 4,
  parameter int DROP_W    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [NUM_MATCH-1:0] match,
  input  logic                 rd_ready,
  output logic                 rd_valid,
  output logic [NUM_MATCH-1:0] rd_match,
  output logic [OFF_W-1:0]     rd_offset,
  output logic [AW:0]          level,
  output logic                 overflow,
  output logic [DROP_W-1:0]    drop_cnt,
  input  logic                 clr_ovf
);

  localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

  logic [OFF_W-1:0]     offset;
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [NUM_MATCH-1:0] mem_match [DEPTH];
  logic [OFF_W-1:0]     mem_off   [DEPTH];

  logic full;
  logic push_req;
  logic pop;
  logic push;
  logic drop;

  assign full     = (level == FULL_LEVEL);
  assign rd_valid = (level != '0);
  assign push_req = en && (|match);
  assign pop      = rd_valid && rd_ready;
  // A pop in the same edge frees the slot, so a push into a full FIFO is
  // still accepted when the host is draining.
  assign push     = push_req && (!full || pop);
  assign drop     = push_req && full && !pop;

  // Head record is read straight from storage; masked while empty so the
  // outputs read zero out of reset.
  assign rd_match  = rd_valid ? mem_match[rd_ptr] : '0;
  assign rd_offset = rd_valid ? mem_off[rd_ptr]   : '0;

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      offset <= '0;
    end else if (en) begin
      offset <= offset + OFF_W'(1);
    end
  end

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   level <= level + (AW+1)'(1);
        2'b01:   level <= level - (AW+1)'(1);
        default: level <= level;
      endcase
    end
  end

  // Storage has no reset; stale contents are unreachable once level is 0.
  always_ff @(negedge clk) begin
    if (push) begin
      mem_match[wr_ptr] <= match;
      mem_off[wr_ptr]   <= offset;
    end
  end

  // A drop coinciding with a clear counts as the first drop after the clear.
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (clr_ovf) begin
      overflow <= drop;
      drop_cnt <= drop ? DROP_W'(1) : '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (drop_cnt != '1) begin
        drop_cnt <= drop_cnt + DROP_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_match_report_fifo.sv
// tb_match_report_fifo
//   Scoreboard bench. The reference model updates on every falling edge. It
//   keeps a record count and an offset counter, and it pushes each accepted
//   record onto an expected-record queue. A monitor samples the DUT two time
//   units after each rising edge. It checks the head record against the front
//   of the queue and pops that entry when the host takes it. The offset
//   counter is 4 bits wide here so that offset wrap occurs within a short run.
module tb_match_report_fifo;

  localparam int NUM_MATCH = 8;
  localparam int OFF_W     = 4;
  localparam int DEPTH     = 16;
  localparam int AW        = 4;
  localparam int DROP_W    = 8;

  typedef struct {
    logic [NUM_MATCH-1:0] m;
    logic [OFF_W-1:0]     o;
  } rec_t;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 en;
  logic [NUM_MATCH-1:0] match;
  logic                 rd_ready;
  logic                 rd_valid;
  logic [NUM_MATCH-1:0] rd_match;
  logic [OFF_W-1:0]     rd_offset;
  logic [AW:0]          level;
  logic                 overflow;
  logic [DROP_W-1:0]    drop_cnt;
  logic                 clr_ovf;

  match_report_fifo #(
    .NUM_MATCH(NUM_MATCH), .OFF_W(OFF_W), .DEPTH(DEPTH), .AW(AW), .DROP_W(DROP_W)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .match(match), .rd_ready(rd_ready),
    .rd_valid(rd_valid), .rd_match(rd_match), .rd_offset(rd_offset),
    .level(level), .overflow(overflow), .drop_cnt(drop_cnt), .clr_ovf(clr_ovf)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  rec_t exp_q[$];
  int   mlevel = 0;
  int   moff   = 0;
  int   movf   = 0;
  int   mdc    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the FIFO as a count plus a queue of records.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      bit pop_now, preq, drop_now;
      rec_t r;
      pop_now  = (mlevel != 0) && rd_ready;
      preq     = en && (match != 0);
      drop_now = 1'b0;
      if (preq && (mlevel < DEPTH || pop_now)) begin
        r.m = match;
        r.o = OFF_W'(moff);
        exp_q.push_back(r);
        mlevel = mlevel + 1;
      end else if (preq) begin
        drop_now = 1'b1;
      end
      if (pop_now) mlevel = mlevel - 1;
      if (clr_ovf) begin
        movf = 0;
        mdc  = 0;
      end
      if (drop_now) begin
        movf = 1;
        if (mdc < (1 << DROP_W) - 1) mdc = mdc + 1;
      end
      if (en) moff = (moff + 1) % (1 << OFF_W);
    end
  end

  // Monitor: compares the presented head record and status against the model.
  always @(posedge clk) begin
    #2;
    if (rst === 1'b1) begin
      check("rd_valid", {31'd0, rd_valid}, {31'd0, mlevel != 0});
      check("level", 32'(level), 32'(mlevel));
      check("overflow", {31'd0, overflow}, 32'(movf));
      check("drop_cnt", 32'(drop_cnt), 32'(mdc));
      if (rd_valid) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL head_record: got valid record m=%0h o=%0h expected none", rd_match, rd_offset);
        end else begin
          check("rd_match", 32'(rd_match), 32'(exp_q[0].m));
          check("rd_offset", 32'(rd_offset), 32'(exp_q[0].o));
          if (rd_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic step(input logic e, input logic [NUM_MATCH-1:0] m, input logic rr, input logic c);
    @(posedge clk);
    en       = e;
    match    = m;
    rd_ready = rr;
    clr_ovf  = c;
    @(negedge clk);
    #1;
  endtask

  // Reset asserted between edges; outputs must clear without a clock edge.
  task automatic do_reset();
    @(posedge clk);
    en       = 1'b0;
    match    = '0;
    rd_ready = 1'b0;
    clr_ovf  = 1'b0;
    #3;
    rst = 1'b0;
    exp_q.delete();
    mlevel = 0;
    moff   = 0;
    movf   = 0;
    mdc    = 0;
    #1;
    check("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
    check("rst_level", 32'(level), 32'd0);
    check("rst_overflow", {31'd0, overflow}, 32'd0);
    check("rst_drop_cnt", 32'(drop_cnt), 32'd0);
    check("rst_rd_match", 32'(rd_match), 32'd0);
    check("rst_rd_offset", 32'(rd_offset), 32'd0);
    @(negedge clk);
    #2;
    rst = 1'b1;
  endtask

  initial begin
    rst      = 1'b0;
    en       = 1'b0;
    match    = '0;
    rd_ready = 1'b0;
    clr_ovf  = 1'b0;
    do_reset();

    // One record on the third character
    for (int i = 0; i < 5; i++) step(1'b1, (i == 2) ? 8'h04 : 8'h00, 1'b0, 1'b0);
    check("t1_level", 32'(level), 32'd1);
    check("t1_valid", {31'd0, rd_valid}, 32'd1);
    check("t1_match", 32'(rd_match), 32'h04);
    check("t1_offset", 32'(rd_offset), 32'd2);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check("t1_drained", {31'd0, rd_valid}, 32'd0);

    // Fill past full, then drain in order
    do_reset();
    for (int i = 0; i < 17; i++) step(1'b1, 8'h01, 1'b0, 1'b0);
    check("t2_level", 32'(level), 32'd16);
    check("t2_overflow", {31'd0, overflow}, 32'd1);
    check("t2_drop_cnt", 32'(drop_cnt), 32'd1);
    check("t2_head_offset", 32'(rd_offset), 32'd0);
    for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    check("t2_empty", {31'd0, rd_valid}, 32'd0);
    check("t2_level0", 32'(level), 32'd0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check("t2_no_underflow", 32'(level), 32'd0);

    // Full with simultaneous push and pop
    for (int i = 0; i < 16; i++) step(1'b1, 8'h01, 1'b0, 1'b0);
    check("t3_full", 32'(level), 32'd16);
    step(1'b1, 8'h81, 1'b1, 1'b0);
    check("t3_level_kept", 32'(level), 32'd16);
    check("t3_no_drop", 32'(drop_cnt), 32'd1);
    for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    check("t3_empty", {31'd0, rd_valid}, 32'd0);

    // Offset wrap with continuous draining
    do_reset();
    for (int i = 0; i < 18; i++) step(1'b1, 8'h01 << (i % 8), 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check("t4_empty", 32'(level), 32'd0);

    // en low ignores match
    for (int i = 0; i < 3; i++) step(1'b0, 8'hFF, 1'b0, 1'b0);
    check("t5_no_push", 32'(level), 32'd0);
    step(1'b1, 8'h20, 1'b0, 1'b0);
    check("t5_offset_held", 32'(rd_offset), 32'd2);
    for (int i = 0; i < 17; i++) step(1'b1, 8'h02, 1'b0, 1'b0);
    check("t5_drop2", 32'(drop_cnt), 32'd2);
    step(1'b1, 8'h02, 1'b0, 1'b1);
    check("t5_clr_drop_ovf", {31'd0, overflow}, 32'd1);
    check("t5_clr_drop_cnt", 32'(drop_cnt), 32'd1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    check("t5_clr_ovf", {31'd0, overflow}, 32'd0);
    check("t5_clr_cnt", 32'(drop_cnt), 32'd0);
    for (int i = 0; i < 260; i++) step(1'b1, 8'h04, 1'b0, 1'b0);
    check("t5_saturate", 32'(drop_cnt), 32'hFF);

    // Asynchronous reset with records queued
    for (int i = 0; i < 11; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    check("t6_level5", 32'(level), 32'd5);
    check("t6_ovf_set", {31'd0, overflow}, 32'd1);
    do_reset();
    step(1'b1, 8'h10, 1'b0, 1'b0);
    check("t6_offset0", 32'(rd_offset), 32'd0);
    check("t6_match", 32'(rd_match), 32'h10);

    // Randomized traffic, alternating between filling and draining phases
    for (int i = 0; i < 600; i++) begin
      logic e, rr, c;
      logic [NUM_MATCH-1:0] m;
      e  = ($urandom_range(0, 99) < 75);
      m  = ($urandom_range(0, 99) < 30) ? '0 : NUM_MATCH'($urandom);
      rr = ($urandom_range(0, 99) < (((i / 100) % 2 == 0) ? 25 : 70));
      c  = ($urandom_range(0, 99) < 3);
      step(e, m, rr, c);
    end
    for (int i = 0; i < 20; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    check("final_empty", 32'(level), 32'd0);
    check("final_queue", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
